descrambler: RTL

//  Receive-side inverse of the DisplayPort TX scrambler, four symbols (32 bit) per clk.
//  - Removes the x^16+x^5+x^4+x^3+1 keystream from data symbols.
//  - Restores SR to BS.
//  - Tracks scrambler-reset cadence (lock/error) for loopback and link bring-up.
//  - Sits after 8b/10b decode / lane deskew, before the main-link unpacker.
//  - Symbol order in a word: byte 0 first, byte 3 last.

---
 rtl/descrambler_if.sv | 23 ++
 rtl/descrambler.sv | 112 +++++++++++
 2 files changed

// File: rtl/descrambler_if.sv
// Symbol bus between the lane deskew stage and the descrambler.
// The design takes the slave modport; the driving side takes master.
interface descrambler_if #(
    parameter int ERR_W = 16
);
    logic [31:0]      data_in;
    logic [3:0]       isk_in;
    logic [31:0]      data_out;
    logic [3:0]       isk_out;
    logic             locked;
    logic             sr_err;
    logic [ERR_W-1:0] err_cnt;

    modport slave (
        input  data_in, isk_in,
        output data_out, isk_out, locked, sr_err, err_cnt
    );

    modport master (
        output data_in, isk_in,
        input  data_out, isk_out, locked, sr_err, err_cnt
    );
endinterface

// File: rtl/descrambler.sv
// DisplayPort receive descrambler: four symbols per clock, x^16+x^5+x^4+x^3+1 keystream,
// SR->BS restoration and scrambler-reset cadence tracking (lock / error count).
module descrambler #(
    parameter int SR_PERIOD = 512,
    parameter int ERR_W     = 16
) (
    input logic           clk,
    input logic           resetn,
    descrambler_if.slave  bus
);
    localparam int CNT_W = (SR_PERIOD > 1) ? $clog2(SR_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CS_LAST = CNT_W'(SR_PERIOD - 1);
    localparam logic [15:0] SEED   = 16'hFFFF;
    localparam logic [7:0]  SYM_SR = 8'h1C;
    localparam logic [7:0]  SYM_BS = 8'hBC;

    typedef enum logic {HUNT, LOCKED} state_t;

    state_t           state, state_next;
    logic [15:0]      lfsr, lfsr_next;
    logic [CNT_W-1:0] cs_cnt, cs_next;
    logic [31:0]      data_p1, dout;
    logic [3:0]       isk_p1;
    logic             err_p1, err_next;
    logic [ERR_W-1:0] err_cnt;
    logic [3:0]       sr, bs;
    logic             multi;

    // One keystream bit per shift; Galois form, MSB is the output bit.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], 1'b0} ^ (s[15] ? 16'h0039 : 16'h0000);
    endfunction

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            sr[i] = bus.isk_in[i] && (bus.data_in[8*i +: 8] == SYM_SR);
            bs[i] = bus.isk_in[i] && (bus.data_in[8*i +: 8] == SYM_BS);
        end
        multi = ($countones(sr | bs) > 1);
    end

    // Walk the slots in symbol order: an SR reseeds without consuming keystream,
    // every other symbol (K or data) consumes one keystream byte.
    always_comb begin
        logic [15:0] s;
        logic [7:0]  key;
        logic [7:0]  sym;
        s    = lfsr;
        dout = '0;
        for (int i = 0; i < 4; i++) begin
            sym = bus.data_in[8*i +: 8];
            key = '0;
            if (sr[i]) begin
                s = SEED;
                dout[8*i +: 8] = SYM_BS;
            end else begin
                for (int b = 0; b < 8; b++) begin
                    key[b] = s[15];
                    s = lfsr_step(s);
                end
                dout[8*i +: 8] = bus.isk_in[i] ? sym : (sym ^ key);
            end
        end
        lfsr_next = s;
    end

    always_comb begin
        state_next = state;
        err_next   = multi;
        cs_next    = cs_cnt;
        if (|sr) begin
            cs_next = '0;
            if (state == LOCKED && cs_cnt != CS_LAST)
                err_next = 1'b1;
            state_next = LOCKED;
        end else if (|bs) begin
            cs_next = (cs_cnt == CS_LAST) ? '0 : cs_cnt + 1'b1;
            if (state == LOCKED && cs_cnt == CS_LAST) begin
                err_next   = 1'b1;
                state_next = HUNT;
            end
        end
    end

    // Single register stage: everything below lines up with the word just received.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= HUNT;
            lfsr    <= SEED;
            cs_cnt  <= '0;
            data_p1 <= '0;
            isk_p1  <= '0;
            err_p1  <= 1'b0;
            err_cnt <= '0;
        end else begin
            state   <= state_next;
            lfsr    <= lfsr_next;
            cs_cnt  <= cs_next;
            data_p1 <= dout;
            isk_p1  <= bus.isk_in;
            err_p1  <= err_next;
            if (err_next && err_cnt != {ERR_W{1'b1}})
                err_cnt <= err_cnt + 1'b1;
        end
    end

    assign bus.data_out = data_p1;
    assign bus.isk_out  = isk_p1;
    assign bus.locked   = (state == LOCKED);
    assign bus.sr_err   = err_p1;
    assign bus.err_cnt  = err_cnt;
endmodule
